// File: rtl/ypc_decode_unit.sv
// rtl/ypc_decode_unit.sv - YPC fetch/decode stage: instruction ROM, ADDI/EBREAK decoder, 32-entry register file
module ypc_inst_decode #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] rs1_data,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       imm,
    output logic              aluop,
    output logic              isbreak,
    output logic              reg_write_en,
    output logic [DATA_W-1:0] alu_result
);
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0]  F3_ADDI    = 3'b000;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic              w_is_addi;
    logic              w_is_ebreak;
    logic [DATA_W-1:0] w_imm_ext;

    // Field extraction is unconditional; only the enables depend on the opcode.
    assign rs1_addr = inst[15 +: ADDR_W];
    assign rd_addr  = inst[7 +: ADDR_W];
    assign imm      = {{20{inst[31]}}, inst[31:20]};

    assign w_is_addi   = (inst[6:0] == OPC_OP_IMM) && (inst[14:12] == F3_ADDI);
    assign w_is_ebreak = (inst == INST_EBREAK);

    assign aluop        = w_is_addi;
    assign isbreak      = w_is_ebreak;
    assign reg_write_en = w_is_addi && (rd_addr != '0);

    assign w_imm_ext  = {{(DATA_W-12){inst[31]}}, inst[31:20]};
    assign alu_result = rs1_data + w_imm_ext;
endmodule

module ypc_decode_unit #(
    parameter int ROM_WORDS = 16,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       imm,
    output logic              aluop,
    output logic              isbreak,
    output logic              reg_write_en,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] alu_result,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    localparam int          NREGS       = 1 << ADDR_W;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic [29:0]       w_rom_idx;
    logic [31:0]       w_inst;
    logic              w_unused_pc_lsb;
    logic [DATA_W-1:0] r_regs [0:NREGS-1];

    assign w_rom_idx       = pc[31:2];
    assign w_unused_pc_lsb = ^pc[1:0];

    // Anything outside the programmed words, including past the ROM end, reads as EBREAK.
    always_comb begin
        w_inst = INST_EBREAK;
        if (w_rom_idx < 30'(ROM_WORDS)) begin
            case (w_rom_idx)
                30'd0:   w_inst = 32'h0010_0093;
                30'd1:   w_inst = 32'h0020_8113;
                30'd2:   w_inst = 32'h0031_0193;
                default: w_inst = INST_EBREAK;
            endcase
        end
    end

    assign inst = w_inst;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];

    ypc_inst_decode #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dec (
        .inst         (w_inst),
        .rs1_data     (rs1_data),
        .rs1_addr     (rs1_addr),
        .rd_addr      (rd_addr),
        .imm          (imm),
        .aluop        (aluop),
        .isbreak      (isbreak),
        .reg_write_en (reg_write_en),
        .alu_result   (alu_result)
    );
endmodule

// File: tb/tb_ypc_decode_unit.sv
// tb/tb_ypc_decode_unit.sv - self-checking bench for ypc_decode_unit
module tb_ypc_decode_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1_addr, rd_addr;
    logic [31:0] imm;
    logic        aluop, isbreak, reg_write_en;
    logic [31:0] rs1_data, alu_result;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic [31:0] d_inst, d_rs1_data, d_imm, d_alu;
    logic [4:0]  d_rs1_addr, d_rd_addr;
    logic        d_aluop, d_isbreak, d_rwe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ypc_decode_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .inst         (inst),
        .rs1_addr     (rs1_addr),
        .rd_addr      (rd_addr),
        .imm          (imm),
        .aluop        (aluop),
        .isbreak      (isbreak),
        .reg_write_en (reg_write_en),
        .rs1_data     (rs1_data),
        .alu_result   (alu_result),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata)
    );

    ypc_inst_decode u_dec (
        .inst         (d_inst),
        .rs1_data     (d_rs1_data),
        .rs1_addr     (d_rs1_addr),
        .rd_addr      (d_rd_addr),
        .imm          (d_imm),
        .aluop        (d_aluop),
        .isbreak      (d_isbreak),
        .reg_write_en (d_rwe),
        .alu_result   (d_alu)
    );

    typedef struct {
        logic        reset;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_inst;
        logic [4:0]  e_rs1a;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic        e_aluop;
        logic        e_brk;
        logic        e_rwe;
        logic [31:0] e_rs1d;
        logic [31:0] e_alu;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1d;
        logic [4:0]  e_rs1a;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic        e_aluop;
        logic        e_brk;
        logic        e_rwe;
        logic [31:0] e_alu;
    } dvec_t;

    vec_t  vecs[$];
    dvec_t dvecs[$];

    function automatic vec_t mk(logic rst, logic [31:0] p, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] ei, logic [4:0] ers1, logic [4:0] erd, logic [31:0] eimm,
                                logic eop, logic ebrk, logic erwe, logic [31:0] ers1d, logic [31:0] ealu);
        vec_t v;
        v.reset = rst; v.pc = p; v.wen = w; v.waddr = wa; v.wdata = wd;
        v.e_inst = ei; v.e_rs1a = ers1; v.e_rd = erd; v.e_imm = eimm;
        v.e_aluop = eop; v.e_brk = ebrk; v.e_rwe = erwe; v.e_rs1d = ers1d; v.e_alu = ealu;
        return v;
    endfunction

    function automatic dvec_t mkd(logic [31:0] i, logic [31:0] r, logic [4:0] ers1, logic [4:0] erd,
                                  logic [31:0] eimm, logic eop, logic ebrk, logic erwe, logic [31:0] ealu);
        dvec_t v;
        v.inst = i; v.rs1d = r; v.e_rs1a = ers1; v.e_rd = erd; v.e_imm = eimm;
        v.e_aluop = eop; v.e_brk = ebrk; v.e_rwe = erwe; v.e_alu = ealu;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] I0   = 32'h0010_0093;
    localparam logic [31:0] I1   = 32'h0020_8113;
    localparam logic [31:0] I2   = 32'h0031_0193;

    initial begin
        //               rst pc        wen wa  wdata         inst  rs1 rd imm  op brk rwe rs1_data      alu
        vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,         I0,   0,  1, 1,   1, 0,  1,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h4,    0, 0, 32'h0,         I1,   1,  2, 2,   1, 0,  1,  32'h0,        32'h2));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h1,         I0,   0,  1, 1,   1, 0,  1,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h4,    1, 2, 32'h3,         I1,   1,  2, 2,   1, 0,  1,  32'h1,        32'h3));
        vecs.push_back(mk(0, 32'h8,    1, 3, 32'h6,         I2,   2,  3, 3,   1, 0,  1,  32'h3,        32'h6));
        vecs.push_back(mk(0, 32'hC,    0, 0, 32'h0,         EBRK, 0,  0, 1,   0, 1,  0,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h8,    0, 0, 32'h0,         I2,   2,  3, 3,   1, 0,  1,  32'h3,        32'h6));
        // x0 write discarded; pc low bits ignored
        vecs.push_back(mk(0, 32'h3,    1, 0, 32'hDEADBEEF,  I0,   0,  1, 1,   1, 0,  1,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,         I0,   0,  1, 1,   1, 0,  1,  32'h0,        32'h1));
        // same-cycle write to x1 is not bypassed, then wraps with imm=2
        vecs.push_back(mk(0, 32'h6,    1, 1, 32'hFFFFFFFF,  I1,   1,  2, 2,   1, 0,  1,  32'h1,        32'h3));
        vecs.push_back(mk(0, 32'h4,    0, 0, 32'h0,         I1,   1,  2, 2,   1, 0,  1,  32'hFFFFFFFF, 32'h1));
        vecs.push_back(mk(0, 32'h100,  0, 0, 32'h0,         EBRK, 0,  0, 1,   0, 1,  0,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h3C,   0, 0, 32'h0,         EBRK, 0,  0, 1,   0, 1,  0,  32'h0,        32'h1));
        vecs.push_back(mk(0, 32'h40,   0, 0, 32'h0,         EBRK, 0,  0, 1,   0, 1,  0,  32'h0,        32'h1));
        // reset beats a simultaneous write to x2
        vecs.push_back(mk(1, 32'h4,    1, 2, 32'h55,        I1,   1,  2, 2,   1, 0,  1,  32'hFFFFFFFF, 32'h1));
        vecs.push_back(mk(0, 32'h4,    0, 0, 32'h0,         I1,   1,  2, 2,   1, 0,  1,  32'h0,        32'h2));
        vecs.push_back(mk(0, 32'h8,    0, 0, 32'h0,         I2,   2,  3, 3,   1, 0,  1,  32'h0,        32'h3));

        //                inst           rs1_data      rs1 rd imm           op brk rwe alu
        dvecs.push_back(mkd(32'hFFF08093, 32'h0,        1,  1, 32'hFFFFFFFF, 1, 0,  1,  32'hFFFFFFFF));
        dvecs.push_back(mkd(32'h00108093, 32'hFFFFFFFF, 1,  1, 32'h1,        1, 0,  1,  32'h0));
        dvecs.push_back(mkd(32'h00000033, 32'h12345678, 0,  0, 32'h0,        0, 0,  0,  32'h12345678));
        dvecs.push_back(mkd(32'h00100013, 32'h0,        0,  0, 32'h1,        1, 0,  0,  32'h1));
        dvecs.push_back(mkd(32'h00101093, 32'h0,        0,  1, 32'h1,        0, 0,  0,  32'h1));
        dvecs.push_back(mkd(32'h00200073, 32'h0,        0,  0, 32'h2,        0, 0,  0,  32'h2));
        dvecs.push_back(mkd(32'h80000093, 32'h800,      0,  1, 32'hFFFFF800, 1, 0,  1,  32'h0));

        reset = 1'b1; pc = 32'h0; wen = 1'b0; waddr = '0; wdata = '0;
        d_inst = '0; d_rs1_data = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].reset; pc = vecs[i].pc;
            wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            #1;
            chk("inst",         i, inst,                 vecs[i].e_inst);
            chk("rs1_addr",     i, {27'b0, rs1_addr},    {27'b0, vecs[i].e_rs1a});
            chk("rd_addr",      i, {27'b0, rd_addr},     {27'b0, vecs[i].e_rd});
            chk("imm",          i, imm,                  vecs[i].e_imm);
            chk("aluop",        i, {31'b0, aluop},       {31'b0, vecs[i].e_aluop});
            chk("isbreak",      i, {31'b0, isbreak},     {31'b0, vecs[i].e_brk});
            chk("reg_write_en", i, {31'b0, reg_write_en}, {31'b0, vecs[i].e_rwe});
            chk("rs1_data",     i, rs1_data,             vecs[i].e_rs1d);
            chk("alu_result",   i, alu_result,           vecs[i].e_alu);
        end

        @(negedge clk);
        reset = 1'b0; wen = 1'b0;

        foreach (dvecs[i]) begin
            d_inst = dvecs[i].inst; d_rs1_data = dvecs[i].rs1d;
            #1;
            chk("dec_rs1_addr",     i, {27'b0, d_rs1_addr}, {27'b0, dvecs[i].e_rs1a});
            chk("dec_rd_addr",      i, {27'b0, d_rd_addr},  {27'b0, dvecs[i].e_rd});
            chk("dec_imm",          i, d_imm,               dvecs[i].e_imm);
            chk("dec_aluop",        i, {31'b0, d_aluop},    {31'b0, dvecs[i].e_aluop});
            chk("dec_isbreak",      i, {31'b0, d_isbreak},  {31'b0, dvecs[i].e_brk});
            chk("dec_reg_write_en", i, {31'b0, d_rwe},      {31'b0, dvecs[i].e_rwe});
            chk("dec_alu_result",   i, d_alu,               dvecs[i].e_alu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ypc_decode_unit.md
# ypc_decode_unit

Combinational instruction fetch and decode stage with a clocked 32×32 integer register file for the single-cycle YPC core. The PC is supplied from outside. The block returns the ROM instruction word, its decoded fields, the rs1 operand and the ADDI sum. The core's sequencer writes results back through the register-file write port. Supported instructions are RV32I ADDI and EBREAK; every other encoding decodes as a no-op.

## Interface
Parameters:
- ROM_WORDS, default 16: instruction ROM depth in 32-bit words.
- ADDR_W, default 5: register address width.
- DATA_W, default 32: register and data width.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  32  byte address of the instruction to fetch.
- inst  out  32  instruction word at pc.
- rs1_addr  out  5  inst[19:15].
- rd_addr  out  5  inst[11:7].
- imm  out  32  inst[31:20], sign-extended to 32 bits.
- aluop  out  1  high when inst is ADDI.
- isbreak  out  1  high when inst is EBREAK.
- reg_write_en  out  1  high for ADDI with rd_addr≠0.
- rs1_data  out  32  current value of register rs1_addr.
- alu_result  out  32  rs1_data+imm, modulo 2^32.
- wen  in  1  register-file write enable.
- waddr  in  5  write address.
- wdata  in  32  write data.

## Operation
ROM:
- Word index is pc[31:2]; pc[1:0] is ignored.
- Default contents:
  - word 0 = 0x00100093 (addi x1,x0,1)
  - word 1 = 0x00208113 (addi x2,x1,2)
  - word 2 = 0x00310193 (addi x3,x2,3)
  - word 3 = 0x00100073 (ebreak)
  - words 4..ROM_WORDS-1 = 0x00100073
- Index ≥ ROM_WORDS returns 0x00100073, so a runaway PC halts.
- The ROM is read-only and is not affected by reset.

Decoder (purely combinational):
- ADDI: opcode inst[6:0]=0010011 and funct3 inst[14:12]=000. Sets aluop=1.
- EBREAK: inst==0x00100073 exactly. Sets isbreak=1 and aluop=0.
- Any other encoding: aluop=0, isbreak=0, reg_write_en=0.
- rs1_addr, rd_addr and imm are always driven from the field positions, whatever the opcode.

Register file:
- 32 entries of DATA_W bits.
- x0 always reads 0; writes to x0 are discarded.
- Read is asynchronous: rs1_data follows rs1_addr and register contents combinationally.
- Write occurs on the rising edge of clk when wen=1 and waddr≠0.
- Reset clears all entries to 0 on the clock edge. While reset is high, reset wins over a simultaneous write.
- No write-to-read bypass: rs1_data shows the old value until after the write edge.

Arithmetic: alu_result is a DATA_W-bit wrap-around sum. Carry and overflow are dropped.

## Timing
- inst, decode outputs, rs1_data and alu_result have zero-cycle combinational latency from pc and register state.
- Register writes become visible on rs1_data immediately after the capturing edge. The result is one-cycle write-to-read latency.
- Values after reset: all registers 0. With pc=0 the outputs are:
  - inst=0x00100093, aluop=1, rd_addr=1, imm=1, rs1_data=0, alu_result=1.
- Reset asserted mid-program clears every register at the next edge. pc is external and is not touched by this block.
- There is no handshake; the block accepts any pc every cycle.

## Test plan
- Reset, then drive pc=0 → inst=0x00100093, aluop=1, isbreak=0, reg_write_en=1, rd_addr=1, rs1_addr=0, imm=1, alu_result=1.
- Sequence pc 0,4,8, writing alu_result to rd_addr each cycle, then pc=12:
  - x1=1, x2=3, x3=6.
  - At pc=12: isbreak=1, aluop=0.
- Negative immediate: write inst 0xFFF08093 (addi x1,x1,-1) with x1=0 → imm=0xFFFFFFFF, alu_result=0xFFFFFFFF.
- Wrap-around: x1=0xFFFFFFFF, imm=1 → alu_result=0x00000000.
- x0 protection:
  - wen=1, waddr=0, wdata=0xDEADBEEF → reading x0 returns 0.
  - Same-cycle read of x5 during a write to x5 returns the old value, then the new value next cycle.
- Reset after x1..x3 are nonzero → all read 0 next cycle.
  - Also check pc=0x100 (beyond ROM) → inst=0x00100073, isbreak=1.
  - Also check an unknown opcode, e.g. 0x00000033 → all enables 0.
